rvx_debouncer: RTL

Conditions one raw, asynchronous, bouncing board input (push-button or switch) into a clean, synchronous, debounced level plus one-cycle press/release pulses. Sits directly upstream of the rvx_ocelot instance in board top-levels. Its debounced level drives rvx_ocelot reset_n, either directly or inverted, or drives a GPIO input. Runs in the rvx_ocelot clock domain.

---
 rtl/rvx_debouncer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rvx_debouncer.sv
// rvx_debouncer: synchronises one raw bouncing button input and emits a clean level plus
// one-cycle press/release pulses. Define RVX_DEBOUNCER_LONG_PRESS_EN to enable long_press.
module rvx_debouncer #(
   parameter int CLOCK_FREQUENCY_HZ = 50000000,
   parameter int DEBOUNCE_TIME_US   = 10000,
   parameter int SYNC_STAGES        = 2,
   parameter int INPUT_ACTIVE_LEVEL = 1,
   parameter int LONG_PRESS_TIME_US = 1000000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic button_in,
   output logic button_level,
   output logic button_pressed,
   output logic button_released,
   output logic long_press
);

   localparam int DEBOUNCE_CYCLES = CLOCK_FREQUENCY_HZ / 1000000 * DEBOUNCE_TIME_US;
   localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(DEBOUNCE_CYCLES - 2);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic ACTIVE_LEVEL = (INPUT_ACTIVE_LEVEL != 0);

   if (DEBOUNCE_CYCLES < 2) begin : g_badDebounce
      $error("rvx_debouncer: DEBOUNCE_CYCLES must be >= 2");
   end
   if (SYNC_STAGES < 2) begin : g_badSync
      $error("rvx_debouncer: SYNC_STAGES must be >= 2");
   end
   if (LONG_PRESS_TIME_US < 0) begin : g_badLongPress
      $error("rvx_debouncer: LONG_PRESS_TIME_US must be non-negative");
   end

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_PENDING,
      PRESSED,
      RELEASE_PENDING
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_syncIn;
   state_t                 r_state;
   state_t                 w_stateNext;
   logic [CNT_W-1:0]       r_count;
   logic [CNT_W-1:0]       w_countNext;
   logic                   w_commitPress;
   logic                   w_commitRelease;
   logic                   r_level;
   logic                   r_pressed;
   logic                   r_released;

   // Normalise to 1 = pressed before the first flop so every later stage is polarity-free.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], (button_in == ACTIVE_LEVEL)};
      end
   end

   assign w_syncIn = r_sync[SYNC_STAGES-1];

   // The cycle that enters a pending state is the first stable sample, so the commit
   // fires once the count of further stable samples reaches DEBOUNCE_CYCLES-1.
   always_comb begin
      w_stateNext     = r_state;
      w_countNext     = r_count;
      w_commitPress   = 1'b0;
      w_commitRelease = 1'b0;
      case (r_state)
         RELEASED: begin
            if (w_syncIn) begin
               w_stateNext = PRESS_PENDING;
               w_countNext = '0;
            end
         end
         PRESS_PENDING: begin
            if (!w_syncIn) begin
               w_stateNext = RELEASED;
               w_countNext = '0;
            end else if (r_count == CNT_COMMIT) begin
               w_stateNext   = PRESSED;
               w_countNext   = '0;
               w_commitPress = 1'b1;
            end else if (r_count != CNT_MAX) begin
               w_countNext = r_count + 1'b1;
            end
         end
         PRESSED: begin
            if (!w_syncIn) begin
               w_stateNext = RELEASE_PENDING;
               w_countNext = '0;
            end
         end
         RELEASE_PENDING: begin
            if (w_syncIn) begin
               w_stateNext = PRESSED;
               w_countNext = '0;
            end else if (r_count == CNT_COMMIT) begin
               w_stateNext     = RELEASED;
               w_countNext     = '0;
               w_commitRelease = 1'b1;
            end else if (r_count != CNT_MAX) begin
               w_countNext = r_count + 1'b1;
            end
         end
         default: begin
            w_stateNext = RELEASED;
            w_countNext = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= RELEASED;
         r_count    <= '0;
         r_level    <= 1'b0;
         r_pressed  <= 1'b0;
         r_released <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_count    <= w_countNext;
         r_pressed  <= w_commitPress;
         r_released <= w_commitRelease;
         if (w_commitPress) begin
            r_level <= 1'b1;
         end else if (w_commitRelease) begin
            r_level <= 1'b0;
         end
      end
   end

   assign button_level    = r_level;
   assign button_pressed  = r_pressed;
   assign button_released = r_released;

`ifdef RVX_DEBOUNCER_LONG_PRESS_EN
   localparam int LONG_PRESS_CYCLES = CLOCK_FREQUENCY_HZ / 1000000 * LONG_PRESS_TIME_US;
   localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [LP_W-1:0] LP_FULL = LP_W'(LONG_PRESS_CYCLES);

   if (LONG_PRESS_CYCLES < 1) begin : g_badLongCycles
      $error("rvx_debouncer: LONG_PRESS_CYCLES must be >= 1");
   end

   logic [LP_W-1:0] r_holdCount;
   logic            r_longPress;
   logic            w_holding;

   assign w_holding = (r_state == PRESSED) || (r_state == RELEASE_PENDING);

   // Saturating at the target makes the pulse fire at most once per press.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_holdCount <= '0;
         r_longPress <= 1'b0;
      end else begin
         r_longPress <= 1'b0;
         if (w_commitPress || w_commitRelease) begin
            r_holdCount <= '0;
         end else if (w_holding && (r_holdCount != LP_FULL)) begin
            r_holdCount <= r_holdCount + 1'b1;
            r_longPress <= (r_holdCount == LP_LAST);
         end
      end
   end

   assign long_press = r_longPress;
`else
   assign long_press = 1'b0;
`endif

endmodule
